// File: rtl/npc_pkg.sv
// Shared fetch-path definitions: default widths, reset PC and fetch FSM states.
package npc_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          IW_DEF       = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. Head entry is read straight from storage,
// so a pushed entry appears on pop_data the cycle after the push.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetches under a credit limit,
// queues in-order responses for decode, and squashes in-flight fetches on
// redirect by counting how many responses still belong to the old stream.
//
// state | meaning
// FETCH | issuing requests while credits allow
// HALT  | a live response faulted; no new requests until redirect
module ifu_prefetch
    import npc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              DEPTH    = 4,
    parameter int              IW       = IW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [IW-1:0]   mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [IW-1:0]   inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = IW + XLEN + 1;

    localparam logic [0:0] ST_FETCH = 1'(FETCH);
    localparam logic [0:0] ST_HALT  = 1'(HALT);

    logic [0:0]      state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] req_addr_q;
    logic            req_pend_q;
    logic            req_stale_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   stale_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [EW-1:0]   fifo_wdata;
    logic [EW-1:0]   fifo_rdata;

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_stale;
    logic            rsp_keep;
    logic [XLEN-1:0] redirect_pc_al;
    logic            head_err;

    assign redirect_pc_al = redirect_pc & ~XLEN'(3);

    // Outstanding fetches plus queued entries may never exceed the queue size,
    // so every live response is guaranteed a slot.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);

    // A presented request stays up with its address frozen until accepted.
    assign mem_req_valid = rst_n & (req_pend_q | (state_q == ST_FETCH && credit_ok));
    assign mem_req_addr  = req_pend_q ? req_addr_q : fetch_pc_q;

    assign req_fire   = mem_req_valid && mem_req_ready;
    assign rsp_accept = mem_rsp_valid;
    assign rsp_stale  = (stale_q != '0);
    assign rsp_keep   = rsp_accept && !rsp_stale;

    assign fifo_push  = rsp_keep && (!fifo_full || fifo_pop);
    assign fifo_pop   = inst_valid && inst_ready;
    assign fifo_wdata = {mem_rsp_data, rsp_pc_q, mem_rsp_err};

    assign inst_valid = !fifo_empty;
    assign {inst_data, inst_pc, head_err} = fifo_rdata;
    assign inst_err   = inst_valid && head_err;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM: a faulting live response stops issue; redirect always restarts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else if (redirect_valid) begin
            state_q <= ST_FETCH;
        end else if (rsp_keep && mem_rsp_err) begin
            state_q <= ST_HALT;
        end
    end

    // Fetch and response PCs; a stale request firing does not advance fetch_pc
    // because it carries an address from the abandoned stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc_al;
            rsp_pc_q   <= redirect_pc_al;
        end else begin
            if (req_fire && !req_stale_q) fetch_pc_q <= fetch_pc_q + XLEN'(4);
            if (rsp_keep)                 rsp_pc_q   <= rsp_pc_q + XLEN'(4);
        end
    end

    // Remember a presented-but-unaccepted request; if a redirect lands while it
    // waits, its eventual response belongs to the old stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pend_q  <= 1'b0;
            req_stale_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            req_pend_q  <= mem_req_valid && !mem_req_ready;
            req_stale_q <= mem_req_valid && !mem_req_ready && (redirect_valid || req_stale_q);
            if (mem_req_valid && !mem_req_ready) req_addr_q <= mem_req_addr;
        end
    end

    // In-flight and to-be-discarded response counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_accept);
            if (redirect_valid) begin
                stale_q <= outstanding_q + CW'(req_fire) - CW'(rsp_accept);
            end else begin
                stale_q <= stale_q + CW'(req_fire && req_stale_q) - CW'(rsp_accept && rsp_stale);
            end
        end
    end

endmodule
